// File: rtl/pendulum_angle_encoder_pkg.sv
// Shared definitions for the pendulum angle sensor path: bus width default,
// quadrature state encodings and the encoder FSM states.
package pendulum_pkg;

    localparam int unsigned AngleWDef = 8;

    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_01 = 2'b01;
    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_10 = 2'b10;

    typedef enum logic [0:0] {StInit, StTrack} fsm_state_e;

    typedef enum logic [1:0] {StepNone, StepFwd, StepRev, StepErr} step_e;

    // Position of a quadrature state along the forward cycle 00->01->11->10.
    function automatic logic [1:0] qs_pos(input logic [1:0] qs);
        logic [1:0] pos;
        unique case (qs)
            QS_00:   pos = 2'd0;
            QS_01:   pos = 2'd1;
            QS_11:   pos = 2'd2;
            default: pos = 2'd3;
        endcase
        return pos;
    endfunction

    function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] diff;
        step_e      step;
        diff = qs_pos(cur) - qs_pos(prev);
        unique case (diff)
            2'd0:    step = StepNone;
            2'd1:    step = StepFwd;
            2'd3:    step = StepRev;
            default: step = StepErr;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/pendulum_angle_encoder_quad_input_filter.sv
// Synchronizer plus debounce for one asynchronous encoder line; a change is
// accepted only after it has been stable for FILT_LEN synchronized cycles.
module quad_input_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filtered
);

    localparam int unsigned CntW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   acc_q, acc_d;
    logic                   synced;

    assign synced   = sync_q[SYNC_STAGES-1];
    assign filtered = acc_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
        acc_d  = acc_q;
        cnt_d  = '0;
        if (synced != acc_q) begin
            // The cycle the counter would reach FILT_LEN is the accept cycle.
            if (cnt_q == CntW'(FILT_LEN - 1)) begin
                acc_d = synced;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            acc_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/pendulum_angle_encoder.sv
// Quadrature encoder to wrapping angle count, published every SAMPLE_DIV clocks.
// Define ANGLE_INDEX_EN to let the encoder index pulse re-zero the count.
module pendulum_angle_encoder
    import pendulum_pkg::*;
#(
    parameter int unsigned ANGLE_W     = AngleWDef,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3,
    parameter int unsigned SAMPLE_DIV  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enc_a,
    input  logic               enc_b,
    input  logic               enc_index,
    input  logic               zero_cal,
    output logic [ANGLE_W-1:0] pendulum_angle_sensor,
    output logic               angle_valid,
    output logic               dir,
    output logic               step_err
);

    localparam int unsigned DivW = $clog2(SAMPLE_DIV);

    logic a_acc, b_acc;
    logic index_clr;

    quad_input_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_filt_a (
        .clk     (clk),
        .reset   (reset),
        .raw     (enc_a),
        .filtered(a_acc)
    );

    quad_input_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_filt_b (
        .clk     (clk),
        .reset   (reset),
        .raw     (enc_b),
        .filtered(b_acc)
    );

`ifdef ANGLE_INDEX_EN
    logic idx_acc;
    logic idx_prev_q;

    quad_input_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_filt_index (
        .clk     (clk),
        .reset   (reset),
        .raw     (enc_index),
        .filtered(idx_acc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_prev_q <= 1'b0;
        end else begin
            idx_prev_q <= idx_acc;
        end
    end

    assign index_clr = idx_acc & ~idx_prev_q;
`else
    logic unused_index;
    assign unused_index = enc_index;
    assign index_clr    = 1'b0;
`endif

    fsm_state_e         state_q, state_d;
    logic [1:0]         prev_q, prev_d;
    logic [ANGLE_W-1:0] count_q, count_d;
    logic [ANGLE_W-1:0] sensor_q, sensor_d;
    logic [DivW-1:0]    div_q, div_d;
    logic               dir_q, dir_d;
    logic               err_q, err_d;
    logic               valid_q, valid_d;
    logic [1:0]         cur_ab;
    logic               div_last;
    step_e              step;

    assign cur_ab   = {a_acc, b_acc};
    assign step     = decode_step(prev_q, cur_ab);
    assign div_last = (div_q == DivW'(SAMPLE_DIV - 1));

    always_comb begin
        state_d  = StTrack;
        prev_d   = cur_ab;
        count_d  = count_q;
        dir_d    = dir_q;
        err_d    = err_q;
        div_d    = div_last ? '0 : div_q + DivW'(1);
        valid_d  = div_last;
        // Publish the count as it stood before this cycle's update.
        sensor_d = div_last ? count_q : sensor_q;

        // prev always tracks the input so a discarded step is not replayed later.
        if (zero_cal) begin
            count_d = '0;
            err_d   = 1'b0;
        end else if (index_clr) begin
            count_d = '0;
        end else if (state_q == StTrack) begin
            unique case (step)
                StepFwd: begin
                    count_d = count_q + ANGLE_W'(1);
                    dir_d   = 1'b1;
                end
                StepRev: begin
                    count_d = count_q - ANGLE_W'(1);
                    dir_d   = 1'b0;
                end
                StepErr:  err_d = 1'b1;
                StepNone: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StInit;
            prev_q   <= QS_00;
            count_q  <= '0;
            sensor_q <= '0;
            div_q    <= '0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            count_q  <= count_d;
            sensor_q <= sensor_d;
            div_q    <= div_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    assign pendulum_angle_sensor = sensor_q;
    assign angle_valid           = valid_q;
    assign dir                   = dir_q;
    assign step_err              = err_q;

endmodule

// File: tb/tb_pendulum_angle_encoder.sv
// Directed bench for pendulum_angle_encoder at default parameters.
module tb_pendulum_angle_encoder;

    localparam int unsigned SampleDiv = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       enc_a, enc_b, enc_index, zero_cal;
    logic [7:0] pendulum_angle_sensor;
    logic       angle_valid, dir, step_err;

    int checks   = 0;
    int failures = 0;

    pendulum_angle_encoder dut (
        .clk                  (clk),
        .reset                (reset),
        .enc_a                (enc_a),
        .enc_b                (enc_b),
        .enc_index            (enc_index),
        .zero_cal             (zero_cal),
        .pendulum_angle_sensor(pendulum_angle_sensor),
        .angle_valid          (angle_valid),
        .dir                  (dir),
        .step_err             (step_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_ab(input logic [1:0] ab, input int hold);
        {enc_a, enc_b} = ab;
        tick(hold);
    endtask

    // Wait (bounded) for the next publish and compare the published angle.
    task automatic expect_angle(input string tag, input logic [7:0] exp);
        logic seen;
        int   n;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 2 * SampleDiv + 2) begin
            tick(1);
            n++;
            if (angle_valid) seen = 1'b1;
        end
        check_eq({tag, "_seen"}, seen, 1'b1);
        check_eq(tag, pendulum_angle_sensor, exp);
    endtask

    initial begin
        reset     = 1'b0;
        enc_a     = 1'b0;
        enc_b     = 1'b0;
        enc_index = 1'b0;
        zero_cal  = 1'b0;

        // Reset state and publish cadence with the encoder at rest.
        tick(3);
        check_eq("rst_sensor", pendulum_angle_sensor, 8'h00);
        check_eq("rst_valid", angle_valid, 1'b0);
        check_eq("rst_dir", dir, 1'b0);
        check_eq("rst_err", step_err, 1'b0);
        reset = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick(1);
            check_eq($sformatf("valid_c%0d", i), angle_valid, (i % 10) == 0);
        end
        check_eq("idle_sensor", pendulum_angle_sensor, 8'h00);
        check_eq("idle_err", step_err, 1'b0);

        // Forward steps, then wrap through 0xFF back to 0x00.
        drive_ab(2'b01, 8);
        drive_ab(2'b11, 8);
        drive_ab(2'b10, 8);
        drive_ab(2'b00, 8);
        expect_angle("fwd4", 8'h04);
        check_eq("fwd_dir", dir, 1'b1);
        for (int i = 0; i < 63; i++) begin
            drive_ab(2'b01, 4);
            drive_ab(2'b11, 4);
            drive_ab(2'b10, 4);
            drive_ab(2'b00, 4);
        end
        tick(8);
        expect_angle("fwd_wrap", 8'h00);

        // Reverse steps below zero.
        drive_ab(2'b10, 8);
        expect_angle("rev_ff", 8'hFF);
        drive_ab(2'b11, 8);
        expect_angle("rev_fe", 8'hFE);
        drive_ab(2'b01, 8);
        expect_angle("rev_fd", 8'hFD);
        check_eq("rev_dir", dir, 1'b0);
        drive_ab(2'b00, 8);
        expect_angle("rev_fc", 8'hFC);

        // Glitch rejection: A high for 2 cycles is dropped, 3+ is accepted (00->10 = reverse).
        drive_ab(2'b10, 2);
        drive_ab(2'b00, 8);
        expect_angle("glitch_hold", 8'hFC);
        check_eq("glitch_err", step_err, 1'b0);
        drive_ab(2'b10, 8);
        expect_angle("a_held", 8'hFB);
        check_eq("a_held_dir", dir, 1'b0);

        // Input edge to count/dir change takes exactly 6 clock edges.
        drive_ab(2'b00, 5);
        check_eq("lat_edge5", dir, 1'b0);
        tick(1);
        check_eq("lat_edge6", dir, 1'b1);
        tick(4);
        expect_angle("lat_count", 8'hFC);

        // Double transition flags an error and leaves the count alone.
        drive_ab(2'b11, 8);
        check_eq("dbl_err", step_err, 1'b1);
        expect_angle("dbl_hold", 8'hFC);

        // zero_cal landing on the same cycle as a forward step wins.
        drive_ab(2'b10, 5);
        zero_cal = 1'b1;
        tick(1);
        zero_cal = 1'b0;
        check_eq("cal_err", step_err, 1'b0);
        tick(8);
        expect_angle("cal_zero", 8'h00);
        drive_ab(2'b00, 8);
        expect_angle("cal_next", 8'h01);

        // Index handling.
        drive_ab(2'b01, 8);
        drive_ab(2'b11, 8);
        drive_ab(2'b10, 8);
        drive_ab(2'b00, 8);
        expect_angle("pre_idx", 8'h05);
        enc_index = 1'b1;
        tick(5);
        enc_index = 1'b0;
        tick(10);
`ifdef ANGLE_INDEX_EN
        expect_angle("idx_clear", 8'h00);
`else
        expect_angle("idx_clear", 8'h05);
`endif
        enc_index = 1'b1;
        drive_ab(2'b01, 8);
        enc_index = 1'b0;
        tick(8);
`ifdef ANGLE_INDEX_EN
        expect_angle("idx_vs_step", 8'h00);
`else
        expect_angle("idx_vs_step", 8'h06);
`endif

        // Asynchronous reset mid-operation, then a clean restart.
        drive_ab(2'b10, 8);
        check_eq("pre_rst_err", step_err, 1'b1);
        reset = 1'b0;
        {enc_a, enc_b} = 2'b00;
        #2;
        check_eq("async_sensor", pendulum_angle_sensor, 8'h00);
        check_eq("async_valid", angle_valid, 1'b0);
        check_eq("async_dir", dir, 1'b0);
        check_eq("async_err", step_err, 1'b0);
        tick(3);
        reset = 1'b1;
        tick(9);
        check_eq("restart_c9", angle_valid, 1'b0);
        tick(1);
        check_eq("restart_c10", angle_valid, 1'b1);
        check_eq("restart_sensor", pendulum_angle_sensor, 8'h00);
        check_eq("restart_err", step_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
